key_track_gen: RTL and testbench

- Converts USB HID keyboard keycodes into the 8-lane keyTrack vector that the target-rectangle renderer consumes.
  - Lanes are numbered 7 (leftmost) to 0 (rightmost).
- Samples once per video frame and emits a one-cycle press pulse per lane for downstream note-hit judging.
- Stretches each lane's highlight for a minimum number of frames so short taps stay visible.
- Sits between the keyboard keycode registers and the VGA drawing blocks.

---
 rtl/key_track_gen.sv | 135 +++++++++++++
 tb/tb_key_track_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/key_track_gen.sv
// rtl/key_track_gen.sv - HID keycodes to per-lane keyTrack/key_press, sampled once per video frame
//
// Purpose:
//   Matches four registered HID keycode slots against eight lane keycodes.
//   The lane state is updated once per synchronised frame_clk rising edge,
//   and each lane's highlight is stretched by HOLD_FRAMES frames after release.
// Ports:
//   Clk            system clock
//   Reset_n        asynchronous active-low reset
//   frame_clk      frame clock (vsync derived), asynchronous to Clk
//   keycode_valid  capture strobe for keycode0..3
//   keycode0..3    HID keycode slots (8'h00 = empty)
//   keyTrack       per-lane highlight level (registered)
//   key_press      per-lane one-cycle pulse on a newly pressed key
//   frame_tick     one-cycle pulse per synchronised frame_clk rising edge
// Optional build macro:
//   ROLLOVER_REJECT_EN - discard a tick while any slot holds 8'h01 (ErrorRollOver)
module key_track_gen #(
    parameter logic [7:0] KEY7        = 8'h04,
    parameter logic [7:0] KEY6        = 8'h16,
    parameter logic [7:0] KEY5        = 8'h07,
    parameter logic [7:0] KEY4        = 8'h09,
    parameter logic [7:0] KEY3        = 8'h0D,
    parameter logic [7:0] KEY2        = 8'h0E,
    parameter logic [7:0] KEY1        = 8'h0F,
    parameter logic [7:0] KEY0        = 8'h33,
    parameter int         HOLD_FRAMES = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       keycode_valid,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic [7:0] keyTrack,
    output logic [7:0] key_press,
    output logic       frame_tick
);

    localparam logic [7:0] HOLD_CNT = 8'(HOLD_FRAMES);
    localparam logic [7:0] LANE_KEY [8] = '{KEY0, KEY1, KEY2, KEY3, KEY4, KEY5, KEY6, KEY7};

    logic [7:0] kc0_q, kc1_q, kc2_q, kc3_q;
    logic       fsync1_q, fsync2_q, fedge_q, frame_tick_q;
    logic [7:0] prev_q, prev_d;
    logic [7:0] cnt_q [8];
    logic [7:0] cnt_d [8];
    logic [7:0] keytrack_q, keytrack_d;
    logic [7:0] key_press_q, key_press_d;
    logic [7:0] cur;
    logic       reject;

    // Empty slots (8'h00) never match, even if a lane is configured as 8'h00.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cur[i] = ((kc0_q == LANE_KEY[i]) && (kc0_q != 8'h00)) ||
                     ((kc1_q == LANE_KEY[i]) && (kc1_q != 8'h00)) ||
                     ((kc2_q == LANE_KEY[i]) && (kc2_q != 8'h00)) ||
                     ((kc3_q == LANE_KEY[i]) && (kc3_q != 8'h00));
        end
    end

`ifdef ROLLOVER_REJECT_EN
    assign reject = (kc0_q == 8'h01) || (kc1_q == 8'h01) ||
                    (kc2_q == 8'h01) || (kc3_q == 8'h01);
`else
    assign reject = 1'b0;
`endif

    // Lane state moves only on a tick; key_press is forced low on every other cycle.
    always_comb begin
        prev_d      = prev_q;
        keytrack_d  = keytrack_q;
        key_press_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (frame_tick_q && !reject) begin
            key_press_d = cur & ~prev_q;
            prev_d      = cur;
            for (int i = 0; i < 8; i++) begin
                // Pre-update counter decides the level, giving HOLD_FRAMES extra ticks.
                keytrack_d[i] = cur[i] | (cnt_q[i] != 8'h00);
                if (cur[i]) begin
                    cnt_d[i] = HOLD_CNT;
                end else if (cnt_q[i] != 8'h00) begin
                    cnt_d[i] = cnt_q[i] - 8'h01;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc0_q        <= 8'h00;
            kc1_q        <= 8'h00;
            kc2_q        <= 8'h00;
            kc3_q        <= 8'h00;
            fsync1_q     <= 1'b0;
            fsync2_q     <= 1'b0;
            fedge_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            prev_q       <= 8'h00;
            keytrack_q   <= 8'h00;
            key_press_q  <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 8'h00;
            end
        end else begin
            if (keycode_valid) begin
                kc0_q <= keycode0;
                kc1_q <= keycode1;
                kc2_q <= keycode2;
                kc3_q <= keycode3;
            end
            fsync1_q     <= frame_clk;
            fsync2_q     <= fsync1_q;
            fedge_q      <= fsync2_q;
            frame_tick_q <= fsync2_q & ~fedge_q;
            prev_q       <= prev_d;
            keytrack_q   <= keytrack_d;
            key_press_q  <= key_press_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keyTrack   = keytrack_q;
    assign key_press  = key_press_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_key_track_gen.sv
// tb/tb_key_track_gen.sv - scoreboard bench for key_track_gen
module tb_key_track_gen;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       keycode_valid = 1'b0;
    logic [7:0] keycode0 = 8'h00;
    logic [7:0] keycode1 = 8'h00;
    logic [7:0] keycode2 = 8'h00;
    logic [7:0] keycode3 = 8'h00;
    logic [7:0] keyTrack;
    logic [7:0] key_press;
    logic       frame_tick;

    int checks = 0;
    int passes = 0;

    logic [15:0] exp_q [$];
    logic        tick_d = 1'b0;

    key_track_gen dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .keycode_valid(keycode_valid),
        .keycode0     (keycode0),
        .keycode1     (keycode1),
        .keycode2     (keycode2),
        .keycode3     (keycode3),
        .keyTrack     (keyTrack),
        .key_press    (key_press),
        .frame_tick   (frame_tick)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: the cycle after frame_tick is the lane-update result.
    always @(negedge Clk) begin
        if (tick_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("keyTrack", {24'h0, keyTrack}, {24'h0, e[15:8]});
                chk("key_press", {24'h0, key_press}, {24'h0, e[7:0]});
                chk("tick_width", {31'h0, frame_tick}, 32'd0);
            end
        end
        tick_d = frame_tick;
    end

    task automatic set_slots(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        @(negedge Clk);
        keycode0 = a; keycode1 = b; keycode2 = c; keycode3 = d;
        keycode_valid = 1'b1;
        @(negedge Clk);
        keycode_valid = 1'b0;
    endtask

    // One frame_clk pulse; optionally strobe keycode0=sim_code on the tick edge itself.
    task automatic do_tick(input logic [7:0] exp_kt, input logic [7:0] exp_kp,
                           input bit simult, input logic [7:0] sim_code);
        int n;
        exp_q.push_back({exp_kt, exp_kp});
        @(negedge Clk);
        frame_clk = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!frame_tick && n < 10);
        chk("tick_latency", n, 3);
        if (simult) begin
            keycode0 = sim_code; keycode1 = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00;
            keycode_valid = 1'b1;
            @(negedge Clk);
            keycode_valid = 1'b0;
        end
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    logic [7:0] ro_tail [4];

    initial begin
        #12;
        chk("rst_keyTrack", {24'h0, keyTrack}, 32'h0);
        chk("rst_key_press", {24'h0, key_press}, 32'h0);
        chk("rst_frame_tick", {31'h0, frame_tick}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single press on lane 7, then held, then released with hold stretch
        set_slots(8'h04, 8'h00, 8'h00, 8'h00);
        do_tick(8'h80, 8'h80, 0, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
        set_slots(8'h00, 8'h00, 8'h00, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
        do_tick(8'h00, 8'h00, 0, 8'h00);

        // One-tick tap on J stretched for three ticks
        set_slots(8'h0D, 8'h00, 8'h00, 8'h00);
        do_tick(8'h08, 8'h08, 0, 8'h00);
        set_slots(8'h00, 8'h00, 8'h00, 8'h00);
        do_tick(8'h08, 8'h00, 0, 8'h00);
        do_tick(8'h08, 8'h00, 0, 8'h00);
        do_tick(8'h08, 8'h00, 0, 8'h00);
        do_tick(8'h00, 8'h00, 0, 8'h00);

        // Multi-key with a duplicate slot
        set_slots(8'h04, 8'h33, 8'h04, 8'h0F);
        do_tick(8'h83, 8'h83, 0, 8'h00);
        set_slots(8'h00, 8'h00, 8'h00, 8'h00);
        do_tick(8'h83, 8'h00, 0, 8'h00);
        do_tick(8'h83, 8'h00, 0, 8'h00);
        do_tick(8'h83, 8'h00, 0, 8'h00);
        do_tick(8'h00, 8'h00, 0, 8'h00);

        // keycode_valid on the tick edge: new code only seen on the next tick
        do_tick(8'h00, 8'h00, 1, 8'h07);
        do_tick(8'h20, 8'h20, 0, 8'h00);
        set_slots(8'h00, 8'h00, 8'h00, 8'h00);
        do_tick(8'h20, 8'h00, 0, 8'h00);
        do_tick(8'h20, 8'h00, 0, 8'h00);
        do_tick(8'h20, 8'h00, 0, 8'h00);
        do_tick(8'h00, 8'h00, 0, 8'h00);

        // ErrorRollOver while lane 7 is held
        set_slots(8'h04, 8'h00, 8'h00, 8'h00);
        do_tick(8'h80, 8'h80, 0, 8'h00);
        set_slots(8'h01, 8'h00, 8'h00, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
        do_tick(8'h80, 8'h00, 0, 8'h00);
`ifdef ROLLOVER_REJECT_EN
        ro_tail = '{8'h80, 8'h80, 8'h80, 8'h00};
`else
        ro_tail = '{8'h80, 8'h00, 8'h00, 8'h00};
`endif
        set_slots(8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) do_tick(ro_tail[i], 8'h00, 0, 8'h00);

        // All eight lanes lit, then asynchronous reset mid-hold
        set_slots(8'h04, 8'h16, 8'h07, 8'h09);
        do_tick(8'hF0, 8'hF0, 0, 8'h00);
        set_slots(8'h0D, 8'h0E, 8'h0F, 8'h33);
        do_tick(8'hFF, 8'h0F, 0, 8'h00);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_keyTrack", {24'h0, keyTrack}, 32'h0);
        chk("async_rst_key_press", {24'h0, key_press}, 32'h0);
        chk("async_rst_frame_tick", {31'h0, frame_tick}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        do_tick(8'h00, 8'h00, 0, 8'h00);

        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
